// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types for the unified-memory port arbiter: FSM state
//            encodings and the access-source tag.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DACC   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_t;

  // True in the two states that own the memory bus.
  function automatic logic arb_is_busy(input arb_state_t s);
    return (s == ST_IFETCH) || (s == ST_DACC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : arb_timeout_cnt
// Purpose  : Cycle counter for outstanding memory accesses. o_expired is
//            asserted in the cycle whose increment would make the count
//            equal to i_limit, so the owner can abort on that same edge.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            i_clear        - zero the count (priority over i_enable)
//            i_enable       - count this cycle
//            i_limit        - abort threshold (>= 1)
//            o_expired      - this enabled cycle reaches i_limit
// Revision : 1.0 - initial release
// ============================================================================
module arb_timeout_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_next;

  // One extra bit so the compare never wraps, even for a limit at full scale.
  assign w_next    = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign o_expired = i_enable && (w_next == {1'b0, i_limit});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_next[CNT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between the IF fetch port and the
//            MEM-stage data port. Data has fixed priority; stalls are raised
//            while an access is outstanding; flushed fetches are discarded;
//            a sticky error flags a memory that never acknowledges.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            global_en                - gates launching of new accesses
//            if_req/if_addr/if_kill   - fetch request, address, flush
//            if_valid/if_rdata        - fetch done pulse and instruction
//            d_req/d_we/d_addr/d_wdata- data request
//            d_valid/d_rdata          - data done pulse and load data
//            stall_fe/stall_mem       - pipeline stall requests
//            m_req/m_we/m_addr/m_wdata- memory request side
//            m_ack/m_rdata            - memory response side
//            err_timeout              - sticky no-acknowledge flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_fe,
  output logic              stall_mem,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err_timeout
);

  localparam int               c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_src_t          r_src;
  logic [ADDR_W-1:0] r_m_addr;
  logic              r_m_we;
  logic [DATA_W-1:0] r_m_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_kill_pend;
  logic              r_err;

  logic w_busy;
  logic w_launch_d;
  logic w_launch_f;
  logic w_ack;
  logic w_expired;
  logic w_abort;
  logic w_kill_now;

  assign w_busy     = arb_is_busy(r_state);
  assign w_launch_d = (r_state == ST_IDLE) && global_en && d_req;
  assign w_launch_f = (r_state == ST_IDLE) && global_en && !d_req && if_req;
  assign w_ack      = w_busy && m_ack;
  // An ack in the expiry cycle completes the access normally.
  assign w_abort    = w_busy && !m_ack && w_expired;
  // A flush seen this cycle counts as well as one remembered earlier, so a
  // kill coinciding with m_ack or with the response cycle still discards.
  assign w_kill_now = r_kill_pend || if_kill;

  arb_timeout_cnt #(
    .CNT_W (c_cnt_w)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_launch_d || w_launch_f),
    .i_enable  (w_busy && !m_ack),
    .i_limit   (c_limit),
    .o_expired (w_expired)
  );

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch_d) begin
          w_state_nxt = ST_DACC;
        end else if (w_launch_f) begin
          w_state_nxt = ST_IFETCH;
        end
      end
      ST_IFETCH, ST_DACC: begin
        if (m_ack) begin
          w_state_nxt = ST_RESP;
        end else if (w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      // The response cycle absorbs the requester's still-asserted req so it
      // is not mistaken for a new access.
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src       <= SRC_FETCH;
      r_m_addr    <= '0;
      r_m_we      <= 1'b0;
      r_m_wdata   <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_kill_pend <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_launch_d) begin
        r_src     <= SRC_DATA;
        r_m_addr  <= d_addr;
        r_m_we    <= d_we;
        r_m_wdata <= d_wdata;
      end else if (w_launch_f) begin
        r_src     <= SRC_FETCH;
        r_m_addr  <= if_addr;
        r_m_we    <= 1'b0;
        r_m_wdata <= '0;
      end

      if (w_ack && (r_src == SRC_FETCH) && !w_kill_now) begin
        r_if_rdata <= m_rdata;
      end
      // Stores leave the previous load data untouched.
      if (w_ack && (r_src == SRC_DATA) && !r_m_we) begin
        r_d_rdata <= m_rdata;
      end

      if (w_state_nxt == ST_IDLE) begin
        r_kill_pend <= 1'b0;
      end else if (if_kill && (r_src == SRC_FETCH) &&
                   ((r_state == ST_IFETCH) || (r_state == ST_RESP))) begin
        r_kill_pend <= 1'b1;
      end

      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ outputs ----
  assign m_req       = w_busy;
  assign m_we        = r_m_we;
  assign m_addr      = r_m_addr;
  assign m_wdata     = r_m_wdata;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign err_timeout = r_err;

  assign if_valid  = (r_state == ST_RESP) && (r_src == SRC_FETCH) && !w_kill_now;
  assign d_valid   = (r_state == ST_RESP) && (r_src == SRC_DATA);

  assign stall_mem = d_req && !d_valid;
  assign stall_fe  = (if_req && !if_valid) || stall_mem;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed, table-driven bench for mem_port_arbiter. A second
//            instance with TIMEOUT=4 exercises the no-acknowledge path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        global_en;
  logic        if_req, if_kill, d_req, d_we, m_ack;
  logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
  logic        if_valid, d_valid, stall_fe, stall_mem, m_req, m_we, err_timeout;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;

  // Timeout instance: only its data request is driven.
  logic        t_d_req;
  logic        t_zero = 1'b0;
  logic [31:0] t_addr = 32'h8000_0040;
  logic [31:0] t_zw   = 32'h0;
  logic        t_if_valid, t_d_valid, t_stall_fe, t_stall_mem, t_m_req, t_m_we, t_err;
  logic [31:0] t_if_rdata, t_d_rdata, t_m_addr, t_m_wdata;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .global_en(global_en),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .stall_fe(stall_fe), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err_timeout(err_timeout)
  );

  mem_port_arbiter #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .global_en(global_en),
    .if_req(t_zero), .if_addr(t_zw), .if_kill(t_zero),
    .if_valid(t_if_valid), .if_rdata(t_if_rdata),
    .d_req(t_d_req), .d_we(t_zero), .d_addr(t_addr), .d_wdata(t_zw),
    .d_valid(t_d_valid), .d_rdata(t_d_rdata),
    .stall_fe(t_stall_fe), .stall_mem(t_stall_mem),
    .m_req(t_m_req), .m_we(t_m_we), .m_addr(t_m_addr), .m_wdata(t_m_wdata),
    .m_ack(t_zero), .m_rdata(t_zw), .err_timeout(t_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        exp_fe;
    logic        exp_mem;
  } stall_vec_t;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;      // m_req cycles without ack before the ack cycle
    logic [31:0] exp_rdata;  // if_rdata / d_rdata seen with the valid pulse
    int          exp_stall;  // cycles of stall_fe (fetch) or stall_mem (data)
  } txn_t;

  stall_vec_t svec[4];
  txn_t       tbl[4];

  task automatic run_txn(input txn_t t, input string tag);
    int stalls = 0;
    global_en = 1'b1;
    if (t.is_data) begin
      d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      if_req = 1'b1; if_addr = t.addr;
    end
    #1;
    stalls += int'(t.is_data ? stall_mem : stall_fe);
    tick;
    for (int i = 0; i <= t.waits; i++) begin
      if (i == 0) begin
        chk({tag, " m_addr"}, m_addr, t.addr);
        chk({tag, " m_we"}, 32'(m_we), 32'(t.we));
        if (t.we) chk({tag, " m_wdata"}, m_wdata, t.wdata);
      end
      chk({tag, " m_req busy"}, 32'(m_req), 32'd1);
      stalls += int'(t.is_data ? stall_mem : stall_fe);
      if (i == t.waits) begin
        m_ack = 1'b1; m_rdata = t.rdata;
      end
      tick;
      m_ack = 1'b0;
    end
    chk({tag, " valid pulse"}, 32'(t.is_data ? d_valid : if_valid), 32'd1);
    chk({tag, " other valid"}, 32'(t.is_data ? if_valid : d_valid), 32'd0);
    chk({tag, " rdata"}, t.is_data ? d_rdata : if_rdata, t.exp_rdata);
    chk({tag, " m_req resp"}, 32'(m_req), 32'd0);
    stalls += int'(t.is_data ? stall_mem : stall_fe);
    tick;
    d_req = 1'b0; if_req = 1'b0;
    #1;
    chk({tag, " valid drop"}, 32'(t.is_data ? d_valid : if_valid), 32'd0);
    chk({tag, " no relaunch"}, 32'(m_req), 32'd0);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(t.exp_stall));
  endtask

  initial begin
    svec[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    svec[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    svec[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
    svec[3] = '{1'b1, 1'b1, 1'b1, 1'b1};

    //           data we   addr          wdata         rdata         w  exp_rdata     stall
    tbl[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0,       32'h0000_0013, 0, 32'h0000_0013, 2};
    tbl[1] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0,       32'h1234_5678, 4, 32'h1234_5678, 6};
    tbl[2] = '{1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1, 32'h1234_5678, 3};
    tbl[3] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0,       32'h00A0_0093, 2, 32'h00A0_0093, 4};

    rst = 1'b1; global_en = 1'b0;
    if_req = 1'b0; if_kill = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; t_d_req = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst m_req", 32'(m_req), 32'd0);
    chk("rst m_addr", m_addr, 32'd0);
    chk("rst if_valid", 32'(if_valid), 32'd0);
    chk("rst d_valid", 32'(d_valid), 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst err", 32'(err_timeout), 32'd0);

    // Stall equations while global_en blocks every launch
    for (int i = 0; i < 4; i++) begin
      if_req = svec[i].if_req; d_req = svec[i].d_req;
      #1;
      chk($sformatf("stall_fe vec%0d", i), 32'(stall_fe), 32'(svec[i].exp_fe));
      chk($sformatf("stall_mem vec%0d", i), 32'(stall_mem), 32'(svec[i].exp_mem));
      tick;
      chk($sformatf("gated m_req vec%0d", i), 32'(m_req), 32'd0);
    end
    if_req = 1'b0; d_req = 1'b0;
    tick;

    // Single accesses: 0-wait fetch, wait-state load, store, waited fetch
    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("txn%0d", i));

    // Collision: data wins, fetch follows
    global_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h0040_0010;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0004; d_wdata = 32'hDEAD_BEEF;
    tick;
    chk("coll m_we", 32'(m_we), 32'd1);
    chk("coll m_addr", m_addr, 32'h8000_0004);
    chk("coll m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("coll stall_mem", 32'(stall_mem), 32'd1);
    chk("coll stall_fe", 32'(stall_fe), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h0;
    tick;
    m_ack = 1'b0;
    chk("coll d_valid", 32'(d_valid), 32'd1);
    chk("coll if_valid", 32'(if_valid), 32'd0);
    chk("coll stall_mem resp", 32'(stall_mem), 32'd0);
    chk("coll stall_fe resp", 32'(stall_fe), 32'd1);
    tick;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("coll idle m_req", 32'(m_req), 32'd0);
    tick;
    chk("coll fetch m_we", 32'(m_we), 32'd0);
    chk("coll fetch m_addr", m_addr, 32'h0040_0010);
    m_ack = 1'b1; m_rdata = 32'h0000_0517;
    tick;
    m_ack = 1'b0;
    chk("coll fetch valid", 32'(if_valid), 32'd1);
    chk("coll fetch rdata", if_rdata, 32'h0000_0517);
    tick;
    if_req = 1'b0;

    // Kill during IFETCH with two wait cycles
    if_req = 1'b1; if_addr = 32'h0040_0008;
    tick;
    chk("kill m_addr", m_addr, 32'h0040_0008);
    if_kill = 1'b1;
    tick;
    if_kill = 1'b0;
    tick;
    m_ack = 1'b1; m_rdata = 32'hBADB_AD00;
    tick;
    m_ack = 1'b0;
    chk("kill no valid", 32'(if_valid), 32'd0);
    chk("kill rdata held", if_rdata, 32'h0000_0517);
    if_addr = 32'h0040_0020;
    tick;
    chk("kill idle valid", 32'(if_valid), 32'd0);
    tick;
    chk("post-kill m_addr", m_addr, 32'h0040_0020);
    m_ack = 1'b1; m_rdata = 32'h0000_0297;
    tick;
    m_ack = 1'b0;
    chk("post-kill valid", 32'(if_valid), 32'd1);
    chk("post-kill rdata", if_rdata, 32'h0000_0297);
    tick;
    if_req = 1'b0;

    // Reset in the middle of a load, late ack afterwards
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0020;
    tick;
    chk("mid-rst m_req before", 32'(m_req), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hCAFE_0001;
    #1;
    chk("mid-rst m_req", 32'(m_req), 32'd0);
    chk("mid-rst m_addr", m_addr, 32'd0);
    chk("mid-rst if_rdata", if_rdata, 32'd0);
    chk("mid-rst d_rdata", d_rdata, 32'd0);
    chk("mid-rst d_valid", 32'(d_valid), 32'd0);
    tick;
    m_ack = 1'b0;
    chk("late ack d_valid", 32'(d_valid), 32'd0);
    chk("late ack d_rdata", d_rdata, 32'd0);
    run_txn(tbl[1], "after-rst load");

    // Timeout with TIMEOUT=4
    global_en = 1'b1; t_d_req = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to m_req c%0d", i + 1), 32'(t_m_req), 32'd1);
      chk($sformatf("to err c%0d", i + 1), 32'(t_err), 32'd0);
      tick;
    end
    chk("to err set", 32'(t_err), 32'd1);
    chk("to m_req drop", 32'(t_m_req), 32'd0);
    chk("to no d_valid", 32'(t_d_valid), 32'd0);
    t_d_req = 1'b0;
    tick; tick; tick;
    chk("to err sticky", 32'(t_err), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("to err cleared", 32'(t_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
